apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 126 ++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// CPU-to-APB master bridge: IDLE/SETUP/ACCESS sequencer, all APB outputs registered.
// Optional ACCESS-phase timeout when APB_BRIDGE_TIMEOUT_EN is defined.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   cpu_req/wr/addr/wdata  CPU request side
//   cpu_addr_ok            request accepted (combinational, IDLE only)
//   cpu_data_ok            one-cycle completion pulse
//   cpu_rdata, cpu_err     read data / timeout abort flag, valid with cpu_data_ok
//   apb_psel_cpu, apb_rw_cpu, apb_enab_cpu, apb_addr_cpu, apb_datai_cpu
//                          APB request toward the address decoder/mux
//   apb_datao_cpu, apb_ack_cpu
//                          APB read data and ready
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cpu_req,
  input  logic                      cpu_wr,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [APB_DATA_WIDTH-1:0] cpu_wdata,
  output logic                      cpu_addr_ok,
  output logic                      cpu_data_ok,
  output logic [APB_DATA_WIDTH-1:0] cpu_rdata,
  output logic                      cpu_err,
  output logic                      apb_psel_cpu,
  output logic                      apb_rw_cpu,
  output logic                      apb_enab_cpu,
  output logic [ADDR_WIDTH-1:0]     apb_addr_cpu,
  output logic [APB_DATA_WIDTH-1:0] apb_datai_cpu,
  input  logic [APB_DATA_WIDTH-1:0] apb_datao_cpu,
  input  logic                      apb_ack_cpu
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;

  assign cpu_addr_ok = (state == IDLE);

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;
  // Abort when the ack-less cycle being counted would make TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  assign cpu_err = err_q;
`else
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      apb_psel_cpu  <= 1'b0;
      apb_enab_cpu  <= 1'b0;
      apb_rw_cpu    <= 1'b0;
      apb_addr_cpu  <= '0;
      apb_datai_cpu <= '0;
      cpu_data_ok   <= 1'b0;
      cpu_rdata     <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      cpu_data_ok <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            apb_rw_cpu    <= cpu_wr;
            apb_addr_cpu  <= cpu_addr;
            apb_datai_cpu <= cpu_wdata;
            apb_psel_cpu  <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          apb_enab_cpu <= 1'b1;
          state        <= ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
          tmo_cnt      <= '0;
`endif
        end
        ACCESS: begin
          if (apb_ack_cpu) begin
            apb_psel_cpu <= 1'b0;
            apb_enab_cpu <= 1'b0;
            cpu_data_ok  <= 1'b1;
            state        <= IDLE;
            if (!apb_rw_cpu) begin
              cpu_rdata <= apb_datao_cpu;
            end
          end
`ifdef APB_BRIDGE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            apb_psel_cpu <= 1'b0;
            apb_enab_cpu <= 1'b0;
            cpu_data_ok  <= 1'b1;
            err_q        <= 1'b1;
            cpu_rdata    <= '0;
            state        <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
